// File: rtl/risco5_bus_pkg.sv
// Shared constants for the Grande-Risco5 memory-side bus responder:
// MMIO register offsets, STATUS bit positions and the default MMIO base.
package risco5_bus_pkg;

    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'h8000_0000;

    localparam logic [15:0] OFF_GPIO    = 16'h0000;
    localparam logic [15:0] OFF_TXDATA  = 16'h0004;
    localparam logic [15:0] OFF_STATUS  = 16'h0008;
    localparam logic [15:0] OFF_SNAP_LO = 16'h0010;
    localparam logic [15:0] OFF_SNAP_HI = 16'h0014;
    localparam logic [15:0] OFF_SNAP    = 16'h0018;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;

endpackage

// File: rtl/risco5_bus_responder_fifo.sv
// Synchronous FIFO with occupancy count and head output.
// Pushes while full and pops while empty are ignored.
module risco5_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = count == (PW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= data_in;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/risco5_bus_responder.sv
// Unified RAM plus MMIO (GPIO, TX FIFO, cycle timer) opposite the core.
// Timer/snapshot present only when RISCO5_RESPONDER_TIMER_EN is defined.
module risco5_bus_responder
    import risco5_bus_pkg::*;
#(
    parameter int          MEM_WORDS  = 4096,
    parameter string       INIT_FILE  = "",
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = DEFAULT_MMIO_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction_address,
    output logic [31:0] instruction_data,
    input  logic        data_memory_read,
    input  logic        data_memory_write,
    input  logic [31:0] data_address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic [31:0] gpio_out,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   mem [MEM_WORDS];
    logic          i_ram;
    logic          d_ram;
    logic          d_mmio;
    logic [15:0]   d_off;
    logic [AW-1:0] i_idx;
    logic [AW-1:0] d_idx;
    logic          wr_gpio;
    logic          wr_tx;
    logic          wr_status;
    logic          overflow;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [7:0]    head;
    logic [31:0]   status;
    logic [31:0]   mmio_rd;
    logic [31:0]   snap_lo;
    logic [31:0]   snap_hi;
    logic          unused_read;

    // Read strobe is advisory; loads are combinational regardless.
    assign unused_read = data_memory_read;

    assign i_ram  = (instruction_address >> (AW + 2)) == 32'd0;
    assign d_ram  = (data_address >> (AW + 2)) == 32'd0;
    assign d_mmio = data_address[31:16] == MMIO_BASE[31:16];
    assign d_off  = {data_address[15:2], 2'b00};
    assign i_idx  = instruction_address[AW+1:2];
    assign d_idx  = data_address[AW+1:2];

    assign wr_gpio   = data_memory_write && d_mmio && d_off == OFF_GPIO;
    assign wr_tx     = data_memory_write && d_mmio && d_off == OFF_TXDATA;
    assign wr_status = data_memory_write && d_mmio && d_off == OFF_STATUS;

    assign instruction_data = i_ram ? mem[i_idx] : 32'h0;

    always_ff @(posedge clk) begin
        if (data_memory_write && d_ram) begin
            mem[d_idx] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_out <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_gpio) gpio_out <= write_data;
            // A push into a full FIFO is dropped even if a pop coincides.
            if (wr_tx && full) begin
                overflow <= 1'b1;
            end else if (wr_status && write_data[ST_OVF]) begin
                overflow <= 1'b0;
            end
        end
    end

    risco5_sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (wr_tx),
        .pop    (tx_ready),
        .data_in(write_data[7:0]),
        .head   (head),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    assign tx_valid = !empty;
    assign tx_data  = empty ? 8'h00 : head;

`ifdef RISCO5_RESPONDER_TIMER_EN
    logic [63:0] timer;
    logic [63:0] snap;
    logic        wr_snap;

    assign wr_snap = data_memory_write && d_mmio && d_off == OFF_SNAP;

    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
            snap  <= '0;
        end else begin
            timer <= timer + 64'd1;
            if (wr_snap) snap <= timer;
        end
    end

    assign snap_lo = snap[31:0];
    assign snap_hi = snap[63:32];
`else
    assign snap_lo = '0;
    assign snap_hi = '0;
`endif

    always_comb begin
        status           = '0;
        status[ST_EMPTY] = empty;
        status[ST_FULL]  = full;
        status[ST_OVF]   = overflow;
        status[15:8]     = 8'(count);
    end

    always_comb begin
        mmio_rd = '0;
        case (d_off)
            OFF_GPIO:    mmio_rd = gpio_out;
            OFF_STATUS:  mmio_rd = status;
            OFF_SNAP_LO: mmio_rd = snap_lo;
            OFF_SNAP_HI: mmio_rd = snap_hi;
            default:     mmio_rd = '0;
        endcase
    end

    always_comb begin
        read_data = '0;
        unique case (1'b1)
            d_ram:   read_data = mem[d_idx];
            d_mmio:  read_data = mmio_rd;
            default: read_data = '0;
        endcase
    end

endmodule

// File: tb/tb_risco5_bus_responder.sv
// Directed self-checking bench for risco5_bus_responder.
// Timer checks follow RISCO5_RESPONDER_TIMER_EN.
module tb_risco5_bus_responder;

    localparam logic [31:0] MB = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction_address;
    logic [31:0] instruction_data;
    logic        data_memory_read;
    logic        data_memory_write;
    logic [31:0] data_address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic [31:0] gpio_out;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    int n_checks = 0;
    int n_fails  = 0;

    risco5_bus_responder dut (
        .clk                (clk),
        .reset              (reset),
        .instruction_address(instruction_address),
        .instruction_data   (instruction_data),
        .data_memory_read   (data_memory_read),
        .data_memory_write  (data_memory_write),
        .data_address       (data_address),
        .write_data         (write_data),
        .read_data          (read_data),
        .gpio_out           (gpio_out),
        .tx_valid           (tx_valid),
        .tx_data            (tx_data),
        .tx_ready           (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        data_address      = a;
        write_data        = d;
        data_memory_write = 1'b1;
        step();
        data_memory_write = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a,
                          input logic [31:0] exp);
        data_address = a;
        #1;
        chk(tag, read_data, exp);
    endtask

    initial begin
        reset               = 1'b1;
        instruction_address = '0;
        data_memory_read    = 1'b0;
        data_memory_write   = 1'b0;
        data_address        = '0;
        write_data          = '0;
        tx_ready            = 1'b0;
        step();
        step();
        chk("rst_gpio", gpio_out, 32'h0);
        chk("rst_txv", {31'h0, tx_valid}, 32'h0);
        chk("rst_txd", {24'h0, tx_data}, 32'h0);
        rd_chk("rst_status", MB + 32'h8, 32'h0000_0001);
        reset = 1'b0;

`ifdef RISCO5_RESPONDER_TIMER_EN
        // Timer is 0 now; after 5 edges it holds 5 when the snap edge hits.
        repeat (5) step();
        wr(MB + 32'h18, 32'h0);
        rd_chk("snap_lo_n", MB + 32'h10, 32'd5);
        rd_chk("snap_hi_n", MB + 32'h14, 32'd0);
`else
        wr(MB + 32'h18, 32'h0);
        rd_chk("snap_lo_off", MB + 32'h10, 32'h0);
        rd_chk("snap_hi_off", MB + 32'h14, 32'h0);
`endif

        wr(32'h40, 32'hDEAD_BEEF);
        rd_chk("ram_rd", 32'h40, 32'hDEAD_BEEF);
        instruction_address = 32'h40;
        #1;
        chk("ifetch", instruction_data, 32'hDEAD_BEEF);
        instruction_address = 32'd4096 * 4;
        #1;
        chk("ifetch_oob", instruction_data, 32'h0);
        rd_chk("rd_oob", 32'h0001_0000, 32'h0);

        data_address      = 32'h40;
        write_data        = 32'h1234_5678;
        data_memory_write = 1'b1;
        #1;
        chk("rdw_old", read_data, 32'hDEAD_BEEF);
        step();
        data_memory_write = 1'b0;
        #1;
        chk("rdw_new", read_data, 32'h1234_5678);

        wr(MB, 32'hA5A5_0001);
        chk("gpio_out", gpio_out, 32'hA5A5_0001);
        rd_chk("gpio_rd", MB, 32'hA5A5_0001);
        rd_chk("unmapped", MB + 32'h20, 32'h0);

        for (int i = 0; i < 8; i++) wr(MB + 32'h4, 32'h41 + i);
        rd_chk("full8", MB + 32'h8, 32'h0000_0802);
        rd_chk("txdata_rd", MB + 32'h4, 32'h0);
        wr(MB + 32'h4, 32'h49);
        rd_chk("ovf_set", MB + 32'h8, 32'h0000_0806);
        wr(MB + 32'h8, 32'h4);
        rd_chk("ovf_clr", MB + 32'h8, 32'h0000_0802);

        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_v", {31'h0, tx_valid}, 32'h1);
            chk("drain_d", {24'h0, tx_data}, 32'h41 + i);
            step();
        end
        tx_ready = 1'b0;
        chk("drained_v", {31'h0, tx_valid}, 32'h0);
        rd_chk("drained_st", MB + 32'h8, 32'h0000_0001);

        wr(MB + 32'h4, 32'h61);
        wr(MB + 32'h4, 32'h62);
        wr(MB + 32'h4, 32'h63);
        rd_chk("cnt3", MB + 32'h8, 32'h0000_0300);
        tx_ready = 1'b1;
        wr(MB + 32'h4, 32'h64);
        tx_ready = 1'b0;
        rd_chk("cnt3_pp", MB + 32'h8, 32'h0000_0300);
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("pp_order", {24'h0, tx_data}, 32'h62 + i);
            step();
        end
        tx_ready = 1'b0;
        chk("pp_empty", {31'h0, tx_valid}, 32'h0);

        for (int i = 0; i < 5; i++) wr(MB + 32'h4, 32'h70 + i);
        rd_chk("cnt5", MB + 32'h8, 32'h0000_0500);
        reset = 1'b1;
        step();
        chk("mid_rst_txv", {31'h0, tx_valid}, 32'h0);
        chk("mid_rst_gpio", gpio_out, 32'h0);
        rd_chk("mid_rst_st", MB + 32'h8, 32'h0000_0001);
        reset = 1'b0;

`ifdef RISCO5_RESPONDER_TIMER_EN
        force dut.timer = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.timer;
        wr(MB + 32'h18, 32'h0);
        wr(MB + 32'h18, 32'h0);
        rd_chk("wrap_lo", MB + 32'h10, 32'h0);
        rd_chk("wrap_hi", MB + 32'h14, 32'h0);
        force dut.timer = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.timer;
        wr(MB + 32'h18, 32'h0);
        rd_chk("max_lo", MB + 32'h10, 32'hFFFF_FFFF);
        rd_chk("max_hi", MB + 32'h14, 32'hFFFF_FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
